sdram_pll_supervisor: RTL and testbench

//  Sequences the SDRAM clock PLL: drives the PLL reset, qualifies its lock output, retries on lock timeout,
//  and releases a clean reset to the SDRAM controller only after a stable lock. Runs in the 50 MHz refclk domain

---
 rtl/sdram_pll_supervisor_pkg.sv | 24 ++
 rtl/sdram_pll_supervisor_if.sv | 55 +++++
 rtl/sdram_pll_supervisor_sync_2ff.sv | 26 ++
 rtl/sdram_pll_supervisor.sv | 135 +++++++++++++
 tb/tb_sdram_pll_supervisor.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pll_supervisor_pkg.sv
// Shared types and helpers for the SDRAM PLL supervisor.
// Optional lock-loss statistics are enabled by defining SDRAM_PLL_SUP_STATS_EN.
package sdram_pll_sup_pkg;

  // Supervisor state; encodings are visible on state_o for debug.
  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } sup_state_e;

  // Width of the shared cycle counter: enough bits to hold the largest
  // terminal count (max - 1). Never less than one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sdram_pll_supervisor_if.sv
// Control/status bundle between the PLL supervisor and its environment
// (PLL lock input, relock/fault-clear requests, resets and status out).
// lock_loss_cnt exists only when SDRAM_PLL_SUP_STATS_EN is defined.
//
// Handshake semantics: there is no valid/ready flow control here.
// force_relock and clr_fault are single-cycle level requests sampled on
// the rising refclk edge; every status output is a registered Moore decode
// that is valid on every cycle. locked is asynchronous and is synchronised
// inside the supervisor.
interface sdram_pll_supervisor_if;
  logic       locked;
  logic       force_relock;
  logic       clr_fault;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [2:0] state_o;
  logic [3:0] retry_cnt;
`ifdef SDRAM_PLL_SUP_STATS_EN
  logic [15:0] lock_loss_cnt;
`endif

  // Supervisor side.
  modport master (
    input  locked,
    input  force_relock,
    input  clr_fault,
    output pll_rst,
    output sys_rst_n,
    output ready,
    output fault,
    output state_o,
`ifdef SDRAM_PLL_SUP_STATS_EN
    output lock_loss_cnt,
`endif
    output retry_cnt
  );

  // Board / PLL / controller side.
  modport slave (
    output locked,
    output force_relock,
    output clr_fault,
    input  pll_rst,
    input  sys_rst_n,
    input  ready,
    input  fault,
    input  state_o,
`ifdef SDRAM_PLL_SUP_STATS_EN
    input  lock_loss_cnt,
`endif
    input  retry_cnt
  );
endinterface

// File: rtl/sdram_pll_supervisor_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Synchronous active-low reset clears both stages to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Capture the async input, then re-register to settle metastability.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sdram_pll_supervisor.sv
// SDRAM PLL supervisor: holds the PLL in reset, waits for a synchronised
// lock, requires a stable lock window before releasing the downstream reset,
// retries on lock timeout and parks in a sticky FAULT after MAX_RETRY
// failed attempts. Runs entirely on refclk.
// Optional macro SDRAM_PLL_SUP_STATS_EN adds a saturating count of
// lock losses seen while running.
module sdram_pll_supervisor
  import sdram_pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 4
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  sdram_pll_supervisor_if.master  bus
);

  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  sup_state_e    r_state;
  sup_state_e    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_retry;
  logic [3:0]    w_retry_nxt;
  logic [3:0]    w_retry_inc;
  logic          w_locked_s;

  sync_2ff u_lock_sync (
    .i_clk   (refclk),
    .i_rst_n (rst_n),
    .i_d     (bus.locked),
    .o_q     (w_locked_s)
  );

  // Saturating increment used when a lock attempt times out.
  assign w_retry_inc = (r_retry == RETRY_MAX) ? r_retry : r_retry + 4'd1;

  // Next-state and retry-count decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    case (r_state)
      ST_RST_PLL: begin
        if (r_cnt == RST_LAST) w_state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (bus.force_relock) begin
          w_state_nxt = ST_RST_PLL;
        end else if (w_locked_s) begin
          w_state_nxt = ST_STABLE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_retry_nxt = w_retry_inc;
          w_state_nxt = (w_retry_inc == RETRY_MAX) ? ST_FAULT : ST_RST_PLL;
        end
      end
      ST_STABLE: begin
        if (bus.force_relock) begin
          w_state_nxt = ST_RST_PLL;
        end else if (!w_locked_s) begin
          // Lock dropped before it proved stable: wait again, not a retry.
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = ST_RUN;
          w_retry_nxt = 4'd0;
        end
      end
      ST_RUN: begin
        if (bus.force_relock || !w_locked_s) w_state_nxt = ST_RST_PLL;
      end
      ST_FAULT: begin
        if (bus.clr_fault) begin
          w_state_nxt = ST_RST_PLL;
          w_retry_nxt = 4'd0;
        end
      end
      default: begin
        w_state_nxt = ST_RST_PLL;
        w_retry_nxt = 4'd0;
      end
    endcase
  end

  // State, shared cycle counter (cleared on every state change, saturating)
  // and retry count.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_state <= ST_RST_PLL;
      r_cnt   <= '0;
      r_retry <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_retry <= w_retry_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Moore output decodes.
  assign bus.pll_rst   = (r_state == ST_RST_PLL) || (r_state == ST_FAULT);
  assign bus.sys_rst_n = (r_state == ST_RUN);
  assign bus.ready     = (r_state == ST_RUN);
  assign bus.fault     = (r_state == ST_FAULT);
  assign bus.state_o   = r_state;
  assign bus.retry_cnt = r_retry;

`ifdef SDRAM_PLL_SUP_STATS_EN
  logic [15:0] r_lock_loss;
  logic        w_lock_loss;

  // Only a genuine lock loss in RUN counts; a forced relock does not.
  assign w_lock_loss = (r_state == ST_RUN) && !bus.force_relock && !w_locked_s;

  // Saturating lock-loss counter; only rst_n clears it.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_lock_loss <= 16'd0;
    end else if (w_lock_loss && (r_lock_loss != 16'hFFFF)) begin
      r_lock_loss <= r_lock_loss + 16'd1;
    end
  end

  assign bus.lock_loss_cnt = r_lock_loss;
`endif

endmodule

// File: tb/tb_sdram_pll_supervisor.sv
// Directed bench for sdram_pll_supervisor. LOCK_TIMEOUT is shortened to
// 300 so the retry/fault path fits in a short run. Cycle numbers below
// count rising edges after reset release; "cyc N" is sampled 1 ns after
// edge N-1, and an input changed at cyc N is first seen by edge N.
module tb_sdram_pll_supervisor;

  localparam int TB_RST    = 16;
  localparam int TB_TMO    = 300;
  localparam int TB_STABLE = 1024;
  localparam int TB_RETRY  = 4;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;

  sdram_pll_supervisor_if bus ();

  sdram_pll_supervisor #(
    .RST_CYCLES    (TB_RST),
    .LOCK_TIMEOUT  (TB_TMO),
    .STABLE_CYCLES (TB_STABLE),
    .MAX_RETRY     (TB_RETRY)
  ) dut (
    .refclk (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  // Clock: 50 MHz refclk.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    int         at_cyc;
    logic       locked_in;
    logic [2:0] st;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry;
    int         lost;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] st, input logic pll,
                          input logic sys, input logic rdy, input logic flt,
                          input logic [3:0] retry);
    chk({tag, ".state"},     32'(bus.state_o),   32'(st));
    chk({tag, ".pll_rst"},   32'(bus.pll_rst),   32'(pll));
    chk({tag, ".sys_rst_n"}, 32'(bus.sys_rst_n), 32'(sys));
    chk({tag, ".ready"},     32'(bus.ready),     32'(rdy));
    chk({tag, ".fault"},     32'(bus.fault),     32'(flt));
    chk({tag, ".retry_cnt"}, 32'(bus.retry_cnt), 32'(retry));
  endtask

  task automatic chk_lost(input string tag, input int exp);
`ifdef SDRAM_PLL_SUP_STATS_EN
    chk({tag, ".lock_loss_cnt"}, 32'(bus.lock_loss_cnt), 32'(exp));
`else
    if (exp < 0) $display("unexpected negative lock-loss expectation in %s", tag);
`endif
  endtask

  // Hold reset for two edges, check reset values, release; cyc restarts at 0.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    bus.force_relock = 1'b0;
    bus.clr_fault    = 1'b0;
    step();
    step();
    chk_outs(tag, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk_lost(tag, 0);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    bus.locked       = 1'b0;
    bus.force_relock = 1'b0;
    bus.clr_fault    = 1'b0;

    // Lock 100 cycles into WAIT_LOCK, run, then lose lock in RUN.
    //          cyc   lk    st    pll   sys   rdy   flt   rty   lost
    vecs[0]  = '{0,    1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 0};
    vecs[1]  = '{1,    1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 0};
    vecs[2]  = '{15,   1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 0};
    vecs[3]  = '{16,   1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 0};
    vecs[4]  = '{116,  1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 0};
    vecs[5]  = '{118,  1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 0};
    vecs[6]  = '{119,  1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 0};
    vecs[7]  = '{1142, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 0};
    vecs[8]  = '{1143, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 0};
    vecs[9]  = '{1200, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 0};
    vecs[10] = '{1202, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 0};
    vecs[11] = '{1203, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1};
    vecs[12] = '{1218, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1};
    vecs[13] = '{1219, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1};

    do_reset("rst0");
    for (int i = 0; i < 14; i++) begin
      run_to(vecs[i].at_cyc);
      chk_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].pll_rst, vecs[i].sys_rst_n,
               vecs[i].ready, vecs[i].fault, vecs[i].retry);
      chk_lost($sformatf("vec%0d", i), vecs[i].lost);
      bus.locked = vecs[i].locked_in;
    end

    // No lock ever: each attempt is 16 + 300 cycles; fourth timeout faults.
    bus.locked = 1'b0;
    do_reset("rst2");
    run_to(316);
    chk_outs("to1", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    run_to(1263);
    chk_outs("to4pre", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
    step();
    chk_outs("fault", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4);
    bus.force_relock = 1'b1;
    step();
    bus.force_relock = 1'b0;
    chk_outs("fault_force", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4);
    run_to(1270);
    bus.clr_fault = 1'b1;
    step();
    bus.clr_fault = 1'b0;
    chk_outs("clr_fault", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    run_to(1287);
    chk_outs("clr_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // One-cycle lock glitch at STABLE cnt=500 sends it back to WAIT_LOCK.
    bus.locked = 1'b1;
    do_reset("rst3");
    run_to(17);
    chk_outs("stable3", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    run_to(515);
    bus.locked = 1'b0;
    step();
    bus.locked = 1'b1;
    step();
    chk_outs("glitch_seen", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    chk_outs("glitch_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    chk_outs("restable", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    run_to(1542);
    chk_outs("run_pre", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    chk_outs("run_fresh", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

    // Forced relock in WAIT_LOCK with locked_s high, and in RUN.
    bus.locked = 1'b0;
    do_reset("rst5");
    run_to(316);
    chk_outs("to1b", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    bus.locked = 1'b1;
    run_to(332);
    chk_outs("wait5", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    bus.force_relock = 1'b1;
    step();
    bus.force_relock = 1'b0;
    chk_outs("force_wait", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    run_to(1373);
    chk_outs("run5_pre", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    step();
    chk_outs("run5", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    run_to(1380);
    bus.force_relock = 1'b1;
    step();
    bus.force_relock = 1'b0;
    chk_outs("force_run", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk_lost("force_run", 0);

    // Reset pulse mid-STABLE restarts from RST_PLL.
    run_to(1500);
    chk_outs("stable6", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b0;
    step();
    chk_outs("rst6", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b1;
    cyc   = 0;
    run_to(15);
    chk_outs("rst6_hold", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    run_to(16);
    chk_outs("rst6_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    run_to(17);
    chk_outs("rst6_stable", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
